// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB types for the TLB maintenance sequencer and its Random/Wired generator.
// Sizes the index type for the largest supported TLB (64 entries); smaller TLBs zero-extend.
package tlb_op_ctrl_pkg;

    localparam int TLB_ENTRIES_DFLT = 16;
    localparam int TLB_INDEX_W      = 6;

    typedef logic [TLB_INDEX_W-1:0] tlb_index_t;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_lo_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_lo_t     lo0;
        tlb_lo_t     lo1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_t;

    // Keeps only the index bits meaningful for a TLB of 'entries' (a power of two).
    function automatic tlb_index_t tlb_index_trunc(input logic [31:0] idx, input int entries);
        return tlb_index_t'(idx & 32'(entries - 1));
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_random_gen.sv
// CP0 Random and Wired registers. With CPU_TLB_WIRED_EN defined, Wired is writable and bounds
// Random from below; otherwise Wired reads 0 and Random simply wraps from 0.
module tlb_random_gen
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DFLT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wired_we,
    input  logic [31:0]                      wired_wdata,
    output logic [$clog2(TLB_ENTRIES)-1:0]   random_idx,
    output logic [$clog2(TLB_ENTRIES):0]     wired_val
);

    localparam int IW = $clog2(TLB_ENTRIES);
    localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

    // Only the low bits of the write data are architecturally stored.
    logic unused_wdata;
    assign unused_wdata = ^{wired_we, wired_wdata};

`ifdef CPU_TLB_WIRED_EN
    logic [IW:0] lower;

    always_comb begin
        lower = (wired_val < (IW+1)'(TLB_ENTRIES)) ? wired_val : (IW+1)'(TLB_ENTRIES - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            random_idx <= TOP;
            wired_val  <= '0;
        end else if (wired_we) begin
            wired_val  <= wired_wdata[IW:0];
            random_idx <= TOP;
        end else if ({1'b0, random_idx} <= lower) begin
            random_idx <= TOP;
        end else begin
            random_idx <= random_idx - IW'(1);
        end
    end
`else
    assign wired_val = '0;

    always_ff @(posedge clk) begin
        if (reset || (random_idx == '0)) begin
            random_idx <= TOP;
        end else begin
            random_idx <= random_idx - IW'(1);
        end
    end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR towards the mmu maintenance ports; every write is
// followed by an mmu_flush pulse. Wired behaviour depends on CPU_TLB_WIRED_EN (see tlb_random_gen).
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    output logic        op_ready,
    input  logic [31:0] cp0_index,
    input  logic [31:0] cp0_entry_hi,
    input  tlb_entry_t  cp0_entry,
    input  logic        wired_we,
    input  logic [31:0] wired_wdata,
    output logic [31:0] random,
    output logic [31:0] wired,
    output tlb_index_t  tlbrw_index,
    output logic        tlbrw_we,
    output tlb_entry_t  tlbrw_wdata,
    input  tlb_entry_t  tlbrw_rdata,
    output logic [31:0] tlbp_entry_hi,
    input  logic [31:0] tlbp_index,
    output logic        done,
    output logic [1:0]  done_type,
    output logic [31:0] result_index,
    output tlb_entry_t  result_entry,
    output logic        mmu_flush
);

    localparam int IW = $clog2(TLB_ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_PROBE, S_READ, S_WRITE, S_FLUSH, S_DONE
    } state_t;

    state_t        state;
    tlb_op_t       op_q;
    logic [IW-1:0] random_idx;
    logic [IW:0]   wired_val;

    tlb_random_gen #(.TLB_ENTRIES(TLB_ENTRIES)) u_random_gen (
        .clk         (clk),
        .reset       (reset),
        .wired_we    (wired_we),
        .wired_wdata (wired_wdata),
        .random_idx  (random_idx),
        .wired_val   (wired_val)
    );

    assign random    = 32'(random_idx);
    assign wired     = 32'(wired_val);
    assign done_type = op_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            op_q          <= TLBP;
            op_ready      <= 1'b1;
            done          <= 1'b0;
            mmu_flush     <= 1'b0;
            tlbrw_we      <= 1'b0;
            tlbrw_index   <= '0;
            tlbrw_wdata   <= '0;
            tlbp_entry_hi <= '0;
            result_index  <= '0;
            result_entry  <= '0;
        end else begin
            tlbrw_we  <= 1'b0;
            mmu_flush <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q          <= tlb_op_t'(op_type);
                        tlbp_entry_hi <= cp0_entry_hi;
                        tlbrw_wdata   <= cp0_entry;
                        op_ready      <= 1'b0;
                        case (tlb_op_t'(op_type))
                            TLBP: state <= S_PROBE;
                            TLBR: begin
                                state       <= S_READ;
                                tlbrw_index <= tlb_index_trunc(cp0_index, TLB_ENTRIES);
                            end
                            TLBWI: begin
                                state       <= S_WRITE;
                                tlbrw_we    <= 1'b1;
                                tlbrw_index <= tlb_index_trunc(cp0_index, TLB_ENTRIES);
                            end
                            default: begin
                                // TLBWR target is frozen here; later Random steps do not move it.
                                state       <= S_WRITE;
                                tlbrw_we    <= 1'b1;
                                tlbrw_index <= tlb_index_t'(random_idx);
                            end
                        endcase
                    end
                end
                S_PROBE: begin
                    result_index <= tlbp_index;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_READ: begin
                    result_entry <= tlbrw_rdata;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_WRITE: begin
                    mmu_flush <= 1'b1;
                    state     <= S_FLUSH;
                end
                S_FLUSH: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the MIPS TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR. It sits between the CP0/execute stage and the `mmu` TLB maintenance ports (`tlbrw_*`, `tlbp_*`), and runs each operation as a short multi-cycle transaction. It owns the CP0 Random and Wired registers. After every TLB write it requests a pipeline refetch, so that MMU results registered before the write are never used.

## Interface
- `TLB_ENTRIES`, 16: number of TLB entries; power of two, 4..64.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: a TLB operation is requested.
- `op_type` in 2: operation code; 0 = TLBP, 1 = TLBR, 2 = TLBWI, 3 = TLBWR.
- `op_ready` out 1: high only in IDLE; an operation is accepted when `op_valid & op_ready`.
- `cp0_index` in 32: CP0 Index; bits [log2(TLB_ENTRIES)-1:0] are used.
- `cp0_entry_hi` in 32: CP0 EntryHi; sampled at accept.
- `cp0_entry` in `tlb_entry_t`: entry assembled from EntryHi/EntryLo0/EntryLo1; sampled at accept.
- `wired_we` in 1: write to the Wired register.
- `wired_wdata` in 32: data for Wired.
- `random` out 32: CP0 Random, zero-extended.
- `wired` out 32: CP0 Wired, zero-extended.
- `tlbrw_index` out `tlb_index_t`: to the mmu.
- `tlbrw_we` out 1: to the mmu.
- `tlbrw_wdata` out `tlb_entry_t`: to the mmu.
- `tlbrw_rdata` in `tlb_entry_t`: from the mmu.
- `tlbp_entry_hi` out 32: to the mmu.
- `tlbp_index` in 32: from the mmu.
- `done` out 1: one-cycle pulse when an operation completes.
- `done_type` out 2: `op_type` of the completed operation.
- `result_index` out 32: TLBP result; P bit is [31], index in the low bits.
- `result_entry` out `tlb_entry_t`: TLBR result.
- `mmu_flush` out 1: one-cycle pulse after a write; the pipeline must refetch.

## Operation
**States:** IDLE, PROBE, READ, WRITE, FLUSH, DONE.

**Accept (IDLE, `op_valid` high):**
- Latch `op_type`, `cp0_entry_hi` and `cp0_entry`.
- Latch the target index: `cp0_index` low bits for TLBWI, the current Random for TLBWR.
- Next state: TLBP → PROBE, TLBR → READ, TLBWI/TLBWR → WRITE.

**Per state:**
- PROBE: drive `tlbp_entry_hi` from the latch; at the end of the cycle sample `tlbp_index` into `result_index`; go to DONE.
- READ: drive `tlbrw_index`; at the end of the cycle sample `tlbrw_rdata` into `result_entry`; go to DONE.
- WRITE: `tlbrw_we`=1 for exactly this cycle, with the latched index and entry; go to FLUSH.
- FLUSH: `mmu_flush`=1; go to DONE.
- DONE: `done`=1 with `done_type`; go to IDLE.

**Outputs outside their active state:** `tlbrw_we`=0. `tlbrw_index` and `tlbp_entry_hi` hold their latched values. `result_*` hold their values until the next TLBP/TLBR overwrites them.

**Random register:**
- Let lower bound L = `wired` if L < TLB_ENTRIES, else L = TLB_ENTRIES-1.
- Every cycle: if Random ≤ L, Random ← TLB_ENTRIES-1; otherwise Random ← Random-1.
- A `wired_we` cycle sets Wired ← `wired_wdata` (low log2(TLB_ENTRIES)+1 bits) and Random ← TLB_ENTRIES-1; this takes priority over the decrement.
- TLBWR uses the Random value sampled at accept. It is not affected by decrements during WRITE.

**Boundary conditions:**
- `op_valid` while busy: ignored (`op_ready`=0); the requester holds it.
- `op_valid` deasserted after accept: the operation still completes; there is no abort.
- `wired_we` during an operation: takes effect immediately and does not change the latched TLBWR index.
- TLBWI with `cp0_index` ≥ TLB_ENTRIES: the index is truncated to its low bits.
- Reset in any state: go to IDLE in the same edge, and no `tlbrw_we`, `mmu_flush` or `done` is asserted after that edge.

**Reset values:**
- State IDLE, `op_ready`=1.
- `done`, `mmu_flush`, `tlbrw_we` = 0.
- Random = TLB_ENTRIES-1, Wired = 0.
- `result_index`, `result_entry`, `tlbrw_index`, `tlbp_entry_hi` = 0.

## Timing
Cycle 0 is the accept cycle.
- TLBP/TLBR: PROBE/READ in cycle 1; `done` and valid `result_*` in cycle 2; `op_ready` again in cycle 3. The mmu returns `tlbp_index` and `tlbrw_rdata` in the cycle its inputs are driven.
- TLBWI/TLBWR: `tlbrw_we` in cycle 1, `mmu_flush` in cycle 2, `done` in cycle 3, `op_ready` in cycle 4.
- Throughput: one operation per 3 cycles (read/probe) or 4 cycles (write).

## Configuration
Macro `CPU_TLB_WIRED_EN`.
- Defined: Wired is a writable register and Random obeys the lower bound L as above.
- Undefined: Wired is hardwired to 0, `wired_we` is ignored, and Random wraps from 0 to TLB_ENTRIES-1.

## Structure
- Shared package `cpu.svh` holds: `tlb_entry_t`, `tlb_index_t`, an op-code enum `tlb_op_t` (TLBP/TLBR/TLBWI/TLBWR), and the `TLB_ENTRIES` default.
- The state enum is local to the module.
- One sub-module, `tlb_random_gen`, holds the Random/Wired registers and their update rule.

## Test plan
- Reset, then idle for 20 cycles with TLB_ENTRIES=16 → Random sequence 15, 14, …, 0, 15, …; `op_ready`=1; `done`=0.
- TLBWI with `cp0_index`=5 → `tlbrw_we` only in cycle 1 with index 5 and the latched entry; `mmu_flush` in cycle 2; `done` in cycle 3 with `done_type`=2.
- TLBP where the mmu returns 0x80000000 → `result_index`=0x80000000 and `done` in cycle 2; `tlbp_entry_hi` equals the EntryHi value present at accept.
- Write Wired=4, then idle → Random goes 15 … 4, 15; then TLBWR at Random=9 → written index 9.
- Assert `reset` in the WRITE state → no `mmu_flush` or `done` follows; `op_ready`=1 in the next cycle.
- Back-to-back TLBR requests with `op_valid` held high → the second is accepted in cycle 3; the first `result_entry` is stable until the second `done`.
